instr_fetch_unit: RTL

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit.sv | 137 +++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: streams words from a 1-cycle-latency memory into a small
// buffer, supports redirects, and has a program-load mode that writes the memory.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clock,
  input  logic        resetn,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_data,
  output logic        mem_wren,
  input  logic [31:0] mem_q,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        load_en,
  input  logic        load_valid,
  input  logic [15:0] load_addr,
  input  logic [31:0] load_data,
  output logic        load_ready,
  output logic [1:0]  dbg_state
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_DRAIN = 2'd1,
    S_LOAD  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [31:0]     r_fetch_pc;
  logic            r_inflight;
  logic [31:0]     r_infl_pc;
  logic [31:0]     r_instr_q [FIFO_DEPTH];
  logic [31:0]     r_pc_q    [FIFO_DEPTH];
  logic [AW-1:0]   r_rd_ptr;
  logic [AW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_count;

  logic            w_nonempty;
  logic            w_pop;
  logic            w_push;
  logic            w_redirect_act;
  logic            w_flush;
  logic            w_issue;
  logic [CW:0]     w_occ;

  // Output handshake: out_instr/out_pc are held while out_valid is high and
  // out_ready is low; an entry transfers on any rising edge with both high.
  assign w_nonempty     = (r_count != '0);
  assign out_valid      = (r_state != S_LOAD) && w_nonempty;
  assign w_pop          = out_valid && out_ready;
  assign out_instr      = r_instr_q[r_rd_ptr];
  assign out_pc         = r_pc_q[r_rd_ptr];
  assign w_redirect_act = (r_state == S_FETCH) && redirect && !load_en;
  assign w_flush        = w_redirect_act || (r_state == S_DRAIN);
  assign w_push         = r_inflight && !w_flush;

  // Occupancy seen by the next issue counts this cycle's pop, so a full
  // buffer that is draining still sustains one fetch per cycle.
  assign w_occ   = {1'b0, r_count} - (CW+1)'(w_pop) + (CW+1)'(r_inflight);
  assign w_issue = (r_state == S_FETCH) && !redirect && !load_en
                   && (w_occ < (CW+1)'(FIFO_DEPTH));

  assign load_ready = (r_state == S_LOAD);
  assign dbg_state  = r_state;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FETCH: if (load_en) w_state_nxt = S_DRAIN;
      S_DRAIN: w_state_nxt = S_LOAD;
      S_LOAD:  if (!load_en) w_state_nxt = S_FETCH;
      default: w_state_nxt = S_FETCH;
    endcase
  end

  always_comb begin
    mem_addr = r_fetch_pc[17:2];
    mem_data = 32'd0;
    mem_wren = 1'b0;
    if (r_state == S_LOAD) begin
      mem_addr = load_addr;
      mem_data = load_data;
      mem_wren = load_valid;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state    <= S_FETCH;
      r_fetch_pc <= RESET_PC;
      r_inflight <= 1'b0;
      r_infl_pc  <= 32'd0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_issue;
      if (w_issue) r_infl_pc <= r_fetch_pc;

      if (w_redirect_act)
        r_fetch_pc <= {redirect_pc[31:2], 2'b00};
      else if ((r_state == S_LOAD) && !load_en)
        r_fetch_pc <= RESET_PC;
      else if (w_issue)
        r_fetch_pc <= r_fetch_pc + 32'd4;

      if (w_flush) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  // Buffer storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_instr_q[r_wr_ptr] <= mem_q;
      r_pc_q[r_wr_ptr]    <= r_infl_pc;
    end
  end

endmodule
